wasm_stack_core: RTL and testbench

- Minimal WebAssembly stack-machine core. Executes a raw, headerless code-byte stream from a byte-addressed ROM, starting at address 0.
- Holds a typed operand stack and runs until `end` or a trap.
- Exposes the top-of-stack value and its type as the program result.
- Sits between the existing genrom code ROM (16-byte window read) and the test/host environment.

---
 rtl/wasm_pkg.sv | 62 ++++++
 rtl/leb128_decoder.sv | 38 +++
 rtl/wasm_stack_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_wasm_stack_core.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/wasm_pkg.sv
// Shared type codes, trap codes, opcodes and FSM state type for the stack core.
// Also defines opcode-enable helper and type-code macros used by benches.
package wasm_pkg;

    localparam logic [1:0] TY_I32 = 2'd0;
    localparam logic [1:0] TY_I64 = 2'd1;
    localparam logic [1:0] TY_F32 = 2'd2;
    localparam logic [1:0] TY_F64 = 2'd3;

    localparam logic [3:0] TRAP_NONE        = 4'd0;
    localparam logic [3:0] TRAP_UNREACHABLE = 4'd1;
    localparam logic [3:0] TRAP_OPCODE      = 4'd2;
    localparam logic [3:0] TRAP_UNDERFLOW   = 4'd3;
    localparam logic [3:0] TRAP_OVERFLOW    = 4'd4;
    localparam logic [3:0] TRAP_MEM         = 4'd5;
    localparam logic [3:0] TRAP_TYPE        = 4'd6;

    localparam logic [7:0] OP_UNREACHABLE = 8'h00;
    localparam logic [7:0] OP_NOP         = 8'h01;
    localparam logic [7:0] OP_END         = 8'h0B;
    localparam logic [7:0] OP_DROP        = 8'h1A;
    localparam logic [7:0] OP_I32_CONST   = 8'h41;
    localparam logic [7:0] OP_I64_CONST   = 8'h42;
    localparam logic [7:0] OP_F32_CONST   = 8'h43;
    localparam logic [7:0] OP_F64_CONST   = 8'h44;
    localparam logic [7:0] OP_I32_EQZ     = 8'h45;
    localparam logic [7:0] OP_I32_ADD     = 8'h6A;
    localparam logic [7:0] OP_I32_SUB     = 8'h6B;
    localparam logic [7:0] OP_I64_ADD     = 8'h7C;
    localparam logic [7:0] OP_I64_SUB     = 8'h7D;
    localparam logic [7:0] OP_I32_REINT   = 8'hBC;
    localparam logic [7:0] OP_I64_REINT   = 8'hBD;
    localparam logic [7:0] OP_F32_REINT   = 8'hBE;
    localparam logic [7:0] OP_F64_REINT   = 8'hBF;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT,
        ST_TRAP
    } state_t;

    // An opcode is disabled when it needs a feature the build leaves out.
    function automatic logic op_enabled(input logic [7:0] op, input logic has_fpu,
                                        input logic use_64b);
        logic is_fp;
        logic is_64;
        is_fp = op inside {OP_F32_CONST, OP_F64_CONST, OP_I32_REINT, OP_I64_REINT,
                           OP_F32_REINT, OP_F64_REINT};
        is_64 = op inside {OP_I64_CONST, OP_F64_CONST, OP_I64_ADD, OP_I64_SUB,
                           OP_I64_REINT, OP_F64_REINT};
        return !(is_fp && !has_fpu) && !(is_64 && !use_64b);
    endfunction

endpackage

`ifndef WASM_TY_I32
`define WASM_TY_I32 2'd0
`define WASM_TY_I64 2'd1
`define WASM_TY_F32 2'd2
`define WASM_TY_F64 2'd3
`endif

// File: rtl/leb128_decoder.sv
// Combinational signed LEB128 decoder: up to 5 bytes (32-bit) or 10 bytes (64-bit).
// valid is low when no terminating byte is found within the allowed length.
module leb128_decoder (
    input  logic [79:0] bytes_in,
    input  logic        is_64,
    output logic [63:0] value,
    output logic [3:0]  len,
    output logic        valid
);

    logic [63:0] acc;
    logic        sign;
    int          shift;

    always_comb begin
        acc   = '0;
        len   = '0;
        valid = 1'b0;
        sign  = 1'b0;
        shift = 0;
        for (int i = 0; i < 10; i++) begin
            if (!valid && (is_64 || i < 5)) begin
                acc = acc | (64'(bytes_in[8*i +: 7]) << (7 * i));
                if (!bytes_in[8*i+7]) begin
                    valid = 1'b1;
                    len   = 4'(i + 1);
                    sign  = bytes_in[8*i+6];
                    shift = 7 * (i + 1);
                end
            end
        end
        if (valid && sign && shift < 64) begin
            acc = acc | (~64'd0 << shift);
        end
        value = is_64 ? acc : {{32{acc[31]}}, acc[31:0]};
    end

endmodule

// File: rtl/wasm_stack_core.sv
// Minimal WebAssembly stack machine: fetches a 16-byte window per instruction,
// decodes and executes it in one cycle, and exposes the registered top of stack.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_FETCH | mem_addr = pc, ROM window arrives next cycle
// ST_EXEC  | decode window, update stack and pc, or halt / trap
// ST_HALT  | end executed; frozen until reset
// ST_TRAP  | fault recorded in trap; frozen until reset
module wasm_stack_core
    import wasm_pkg::*;
#(
    parameter int HAS_FPU     = 1,
    parameter int USE_64B     = 1,
    parameter int MEM_DEPTH   = 4,
    parameter int STACK_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [63:0]        result,
    output logic [1:0]         result_type,
    output logic               result_empty,
    output logic [3:0]         trap,
    output logic [MEM_DEPTH:0] mem_addr,
    output logic [3:0]         mem_extra,
    input  logic [127:0]       mem_data,
    input  logic               mem_error
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    state_t             state_q = ST_FETCH;
    state_t             state_d;
    logic [MEM_DEPTH:0] pc_q = '0;
    logic [MEM_DEPTH:0] pc_d;
    logic [SPW-1:0]     sp_q = '0;
    logic [SPW-1:0]     sp_d;
    logic [3:0]         trap_q = TRAP_NONE;
    logic [3:0]         trap_d;
    logic [63:0]        result_q = '0;
    logic [63:0]        result_d;
    logic [1:0]         result_type_q = TY_I32;
    logic [1:0]         result_type_d;
    logic               result_empty_q = 1'b1;
    logic               result_empty_d;

    logic [63:0] stk_val_q [STACK_DEPTH];
    logic [63:0] stk_val_d [STACK_DEPTH];
    logic [1:0]  stk_ty_q  [STACK_DEPTH];
    logic [1:0]  stk_ty_d  [STACK_DEPTH];

    logic [7:0]  op;
    logic [63:0] leb_value;
    logic [3:0]  leb_len;
    logic        leb_valid;
    logic        unused_window;

    assign op            = mem_data[7:0];
    assign unused_window = ^mem_data[127:88];

    leb128_decoder u_leb (
        .bytes_in (mem_data[87:8]),
        .is_64    (op == OP_I64_CONST),
        .value    (leb_value),
        .len      (leb_len),
        .valid    (leb_valid)
    );

    logic [IW-1:0]  tos_idx;
    logic [IW-1:0]  nos_idx;
    logic [63:0]    tos_v;
    logic [63:0]    nos_v;
    logic [1:0]     tos_t;
    logic [1:0]     nos_t;
    logic           stk_full;

    assign tos_idx  = IW'(sp_q - SPW'(1));
    assign nos_idx  = IW'(sp_q - SPW'(2));
    assign tos_v    = stk_val_q[tos_idx];
    assign nos_v    = stk_val_q[nos_idx];
    assign tos_t    = stk_ty_q[tos_idx];
    assign nos_t    = stk_ty_q[nos_idx];
    assign stk_full = (sp_q == SPW'(STACK_DEPTH));

    logic [3:0]     tcode;
    logic [3:0]     ilen;
    logic [1:0]     n_pop;
    logic           do_push;
    logic           halt;
    logic [63:0]    pval;
    logic [1:0]     pty;
    logic [1:0]     in_ty;
    logic [SPW-1:0] widx;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        trap_d    = trap_q;
        stk_val_d = stk_val_q;
        stk_ty_d  = stk_ty_q;
        tcode     = TRAP_NONE;
        ilen      = 4'd1;
        n_pop     = 2'd0;
        do_push   = 1'b0;
        halt      = 1'b0;
        pval      = '0;
        pty       = TY_I32;
        in_ty     = TY_I32;
        widx      = '0;

        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (mem_error) begin
                    tcode = TRAP_MEM;
                end else if (!op_enabled(op, HAS_FPU != 0, USE_64B != 0)) begin
                    tcode = TRAP_OPCODE;
                end else begin
                    case (op)
                        OP_UNREACHABLE: tcode = TRAP_UNREACHABLE;
                        OP_NOP:         ;
                        OP_END:         halt = 1'b1;
                        OP_DROP: begin
                            if (sp_q == '0) tcode = TRAP_UNDERFLOW;
                            else            n_pop = 2'd1;
                        end
                        OP_I32_CONST, OP_I64_CONST: begin
                            if (!leb_valid)    tcode = TRAP_OPCODE;
                            else if (stk_full) tcode = TRAP_OVERFLOW;
                            else begin
                                do_push = 1'b1;
                                ilen    = 4'd1 + leb_len;
                                if (op == OP_I64_CONST) begin
                                    pty  = TY_I64;
                                    pval = leb_value;
                                end else begin
                                    pty  = TY_I32;
                                    pval = {32'd0, leb_value[31:0]};
                                end
                            end
                        end
                        OP_F32_CONST: begin
                            if (stk_full) tcode = TRAP_OVERFLOW;
                            else begin
                                do_push = 1'b1;
                                ilen    = 4'd5;
                                pty     = TY_F32;
                                pval    = {32'd0, mem_data[39:8]};
                            end
                        end
                        OP_F64_CONST: begin
                            if (stk_full) tcode = TRAP_OVERFLOW;
                            else begin
                                do_push = 1'b1;
                                ilen    = 4'd9;
                                pty     = TY_F64;
                                pval    = mem_data[71:8];
                            end
                        end
                        OP_I32_EQZ, OP_I32_REINT, OP_I64_REINT, OP_F32_REINT, OP_F64_REINT: begin
                            pval = tos_v;
                            case (op)
                                OP_I32_EQZ: begin
                                    in_ty = TY_I32;
                                    pty   = TY_I32;
                                    pval  = {63'd0, tos_v[31:0] == 32'd0};
                                end
                                OP_I32_REINT: begin in_ty = TY_F32; pty = TY_I32; end
                                OP_I64_REINT: begin in_ty = TY_F64; pty = TY_I64; end
                                OP_F32_REINT: begin in_ty = TY_I32; pty = TY_F32; end
                                default:      begin in_ty = TY_I64; pty = TY_F64; end
                            endcase
                            if (sp_q == '0)          tcode = TRAP_UNDERFLOW;
                            else if (tos_t != in_ty) tcode = TRAP_TYPE;
                            else begin
                                n_pop   = 2'd1;
                                do_push = 1'b1;
                            end
                        end
                        OP_I32_ADD, OP_I32_SUB, OP_I64_ADD, OP_I64_SUB: begin
                            in_ty = (op == OP_I64_ADD || op == OP_I64_SUB) ? TY_I64 : TY_I32;
                            pty   = in_ty;
                            case (op)
                                OP_I32_ADD: pval = {32'd0, nos_v[31:0] + tos_v[31:0]};
                                OP_I32_SUB: pval = {32'd0, nos_v[31:0] - tos_v[31:0]};
                                OP_I64_ADD: pval = nos_v + tos_v;
                                default:    pval = nos_v - tos_v;
                            endcase
                            if (sp_q < SPW'(2))                          tcode = TRAP_UNDERFLOW;
                            else if (tos_t != in_ty || nos_t != in_ty)   tcode = TRAP_TYPE;
                            else begin
                                n_pop   = 2'd2;
                                do_push = 1'b1;
                            end
                        end
                        default: tcode = TRAP_OPCODE;
                    endcase
                end

                // A faulting or halting instruction leaves pc and the stack untouched.
                if (tcode != TRAP_NONE) begin
                    state_d = ST_TRAP;
                    trap_d  = tcode;
                end else if (halt) begin
                    state_d = ST_HALT;
                end else begin
                    widx    = sp_q - SPW'(n_pop);
                    sp_d    = widx + SPW'(do_push);
                    pc_d    = pc_q + (MEM_DEPTH + 1)'(ilen);
                    state_d = ST_FETCH;
                    if (do_push) begin
                        stk_val_d[IW'(widx)] = pval;
                        stk_ty_d[IW'(widx)]  = pty;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        result_empty_d = (sp_q == '0);
        result_d       = result_empty_d ? 64'd0 : tos_v;
        result_type_d  = result_empty_d ? TY_I32 : tos_t;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_FETCH;
            pc_q           <= '0;
            sp_q           <= '0;
            trap_q         <= TRAP_NONE;
            result_q       <= '0;
            result_type_q  <= TY_I32;
            result_empty_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            sp_q           <= sp_d;
            trap_q         <= trap_d;
            result_q       <= result_d;
            result_type_q  <= result_type_d;
            result_empty_q <= result_empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stk_val_q <= stk_val_d;
            stk_ty_q  <= stk_ty_d;
        end
    end

    assign result       = result_q;
    assign result_type  = result_type_q;
    assign result_empty = result_empty_q;
    assign trap         = trap_q;
    assign mem_addr     = pc_q;
    assign mem_extra    = 4'd15;

endmodule

// File: tb/tb_wasm_stack_core.sv
// Directed bench for wasm_stack_core: a default core and a HAS_FPU=0,
// STACK_DEPTH=2 core share one 32-byte ROM; expected values are hand-computed.
module tb_wasm_stack_core;
    import wasm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset     = 1'b0;
    logic         mem_error = 1'b0;
    logic [7:0]   rom [32];
    logic [127:0] data_a = '0;
    logic [127:0] data_b = '0;

    logic [63:0] result_a, result_b;
    logic [1:0]  type_a, type_b;
    logic        empty_a, empty_b;
    logic [3:0]  trap_a, trap_b;
    logic [4:0]  addr_a, addr_b;
    logic [3:0]  extra_a, extra_b;

    wasm_stack_core dut_a (
        .clk(clk), .reset(reset), .result(result_a), .result_type(type_a),
        .result_empty(empty_a), .trap(trap_a), .mem_addr(addr_a), .mem_extra(extra_a),
        .mem_data(data_a), .mem_error(mem_error)
    );

    wasm_stack_core #(.HAS_FPU(0), .STACK_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .result(result_b), .result_type(type_b),
        .result_empty(empty_b), .trap(trap_b), .mem_addr(addr_b), .mem_extra(extra_b),
        .mem_data(data_b), .mem_error(mem_error)
    );

    always @(posedge clk) begin
        for (int k = 0; k < 16; k++) begin
            data_a[8*k +: 8] <= rom[addr_a + 5'(k)];
            data_b[8*k +: 8] <= rom[addr_b + 5'(k)];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [95:0] p, input int n);
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int i = 0; i < n; i++) rom[i] = p[8*(n-1-i) +: 8];
    endtask

    task automatic run(input logic [95:0] p, input int n, input int cycles);
        reset = 1'b1;
        load(p, n);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #1;
        check("init_empty", 64'(empty_a), 64'd1);
        check("init_trap",  64'(trap_a),  64'd0);

        reset = 1'b1;
        load(96'h0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", result_a, 64'd0);
        check("rst_type",   64'(type_a),  64'd0);
        check("rst_empty",  64'(empty_a), 64'd1);
        check("rst_trap",   64'(trap_a),  64'd0);
        check("rst_addr",   64'(addr_a),  64'd0);
        check("mem_extra",  64'(extra_a), 64'd15);

        run({8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7C, 8'hBE, 8'h0B}, 8, 15);
        check("p1_result", result_a, 64'h0000_0000_C000_0000);
        check("p1_type",   64'(type_a),  64'(TY_F32));
        check("p1_empty",  64'(empty_a), 64'd0);
        check("p1_trap",   64'(trap_a),  64'd0);

        run({8'h43, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hBC, 8'h0B}, 7, 20);
        check("f32const_result", result_a, 64'hC000_0000);
        check("f32const_type",   64'(type_a), 64'(TY_I32));
        check("f32const_trap",   64'(trap_a), 64'd0);

        run({8'h41, 8'h05, 8'h41, 8'h03, 8'h6B, 8'h0B}, 6, 20);
        check("i32sub_result", result_a, 64'd2);
        check("i32sub_type",   64'(type_a), 64'(TY_I32));

        run({8'h42, 8'h7F, 8'h42, 8'h01, 8'h7C, 8'h0B}, 6, 20);
        check("i64add_wrap_result", result_a, 64'd0);
        check("i64add_wrap_type",   64'(type_a),  64'(TY_I64));
        check("i64add_wrap_empty",  64'(empty_a), 64'd0);

        run({8'h42, 8'h03, 8'h42, 8'h05, 8'h7D, 8'h0B}, 6, 20);
        check("i64sub_result", result_a, 64'hFFFF_FFFF_FFFF_FFFE);

        run({8'h41, 8'h7F, 8'h41, 8'h02, 8'h6A, 8'h0B}, 6, 20);
        check("i32add_wrap_result", result_a, 64'd1);

        run({8'h42, 8'h80, 8'h01, 8'h0B}, 4, 20);
        check("leb2_result", result_a, 64'd128);
        check("leb2_type",   64'(type_a), 64'(TY_I64));

        run({8'h44, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hBD, 8'h0B}, 11, 20);
        check("f64const_result", result_a, 64'h0807_0605_0403_0201);
        check("f64const_type",   64'(type_a), 64'(TY_I64));

        run({8'h41, 8'h00, 8'h45, 8'h0B}, 4, 20);
        check("eqz_result", result_a, 64'd1);

        run({8'h0B}, 1, 20);
        check("end_empty", 64'(empty_a), 64'd1);
        check("end_trap",  64'(trap_a),  64'd0);

        run({8'h1A}, 1, 20);
        check("underflow_trap", 64'(trap_a), 64'(TRAP_UNDERFLOW));
        repeat (10) @(negedge clk);
        check("sticky_trap", 64'(trap_a), 64'(TRAP_UNDERFLOW));
        check("sticky_addr", 64'(addr_a), 64'd0);

        run({8'h00}, 1, 20);
        check("unreachable_trap", 64'(trap_a), 64'(TRAP_UNREACHABLE));

        run({8'h41, 8'h01, 8'hBC}, 3, 20);
        check("type_trap",       64'(trap_a), 64'(TRAP_TYPE));
        check("type_frozen_val", result_a,    64'd1);

        run({8'hFF}, 1, 20);
        check("unknown_trap", 64'(trap_a), 64'(TRAP_OPCODE));

        run({8'h41, 8'h01, 8'hBE, 8'h0B}, 4, 20);
        check("nofpu_trap", 64'(trap_b), 64'(TRAP_OPCODE));
        check("fpu_ok_type", 64'(type_a), 64'(TY_F32));

        run({8'h41, 8'h01, 8'h41, 8'h02, 8'h41, 8'h03}, 6, 20);
        check("overflow_trap",   64'(trap_b), 64'(TRAP_OVERFLOW));
        check("overflow_result", result_b,    64'd2);

        mem_error = 1'b1;
        run({8'h01, 8'h0B}, 2, 20);
        check("memerr_trap", 64'(trap_a), 64'(TRAP_MEM));
        mem_error = 1'b0;

        run({8'h41, 8'h05, 8'h41, 8'h03, 8'h6B, 8'h0B}, 6, 5);
        check("mid_pre_empty", 64'(empty_a), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_empty",  64'(empty_a), 64'd1);
        check("mid_rst_addr",   64'(addr_a),  64'd0);
        check("mid_rst_result", result_a,     64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rerun_result", result_a,    64'd2);
        check("mid_rerun_type",   64'(type_a), 64'(TY_I32));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
